// File: rtl/softmax_pkg.sv
// Shared constants, data word type and sequencer state encoding for the
// softmax arbiter slice.
package softmax_pkg;

    localparam int DEFAULT_WIDTH             = 32;
    localparam int DEFAULT_FIXED_POINT_INDEX = 16;

    typedef logic signed [DEFAULT_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DELIVER
    } arb_state_t;

endpackage

// File: rtl/softmax_arbiter_if.sv
// Requester and engine signals of the softmax arbiter. The arbiter takes the
// slave view; whoever drives requests and models the engine takes master.
interface softmax_arbiter_if #(
    parameter int WIDTH     = 32,
    parameter int DIMENSION = 4,
    parameter int NUM_REQ   = 4
);

    logic [NUM_REQ-1:0]                           req;
    logic [NUM_REQ-1:0][DIMENSION-1:0][WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                           grant;
    logic [NUM_REQ-1:0]                           resp_valid;
    logic [DIMENSION-1:0][WIDTH-1:0]              resp_data;
    logic                                         resp_err;
    logic                                         busy;

    logic                                         sm_start;
    logic [DIMENSION-1:0][WIDTH-1:0]              sm_input_data;
    logic [DIMENSION-1:0][WIDTH-1:0]              sm_output_data;
    logic                                         sm_done;
    logic                                         sm_busy;

    modport slave (
        input  req, req_data, sm_output_data, sm_done, sm_busy,
        output grant, resp_valid, resp_data, resp_err, busy,
               sm_start, sm_input_data
    );

    modport master (
        output req, req_data, sm_output_data, sm_done, sm_busy,
        input  grant, resp_valid, resp_data, resp_err, busy,
               sm_start, sm_input_data
    );

endinterface

// File: rtl/softmax_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] id
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Scanning from the farthest offset down lets the nearest hit win last.
    always_comb begin
        int idx;
        idx   = 0;
        valid = 1'b0;
        id    = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (req[idx]) begin
                valid = 1'b1;
                id    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/softmax_arbiter.sv
// Shares one softmax engine among NUM_REQ requesters: round-robin grant,
// one-cycle engine launch, done/timeout capture and a tagged response pulse.
module softmax_arbiter
    import softmax_pkg::*;
#(
    parameter int WIDTH             = DEFAULT_WIDTH,
    parameter int FIXED_POINT_INDEX = DEFAULT_FIXED_POINT_INDEX,
    parameter int DIMENSION         = 4,
    parameter int NUM_REQ           = 4,
    parameter int TIMEOUT           = 1024
) (
    input  logic              clk,
    input  logic              reset,
    softmax_arbiter_if.slave  bus
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    if (NUM_REQ < 2 || TIMEOUT < 2 || FIXED_POINT_INDEX >= WIDTH) begin : g_bad_params
        $error("softmax_arbiter: unsupported parameter combination");
    end

    arb_state_t                      state;
    arb_state_t                      next_state;
    logic [ID_W-1:0]                 ptr;
    logic [ID_W-1:0]                 id;
    logic [ID_W-1:0]                 win_id;
    logic                            win_valid;
    logic                            timed_out;
    logic [CNT_W-1:0]                cnt;
    logic [DIMENSION-1:0][WIDTH-1:0] resp_data_q;
    logic [DIMENSION-1:0][WIDTH-1:0] sm_input_q;
    logic                            resp_err_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (win_valid),
        .id    (win_id)
    );

    // The counter counts completed WAIT cycles, so reaching TIMEOUT-1 after
    // this cycle's increment means the current value is TIMEOUT-2.
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 2));

    always_comb begin
        next_state     = state;
        bus.grant      = '0;
        bus.resp_valid = '0;
        bus.sm_start   = 1'b0;
        bus.busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (win_valid && !bus.sm_busy) begin
                    next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                bus.grant    = NUM_REQ'(1) << id;
                bus.sm_start = 1'b1;
                next_state   = WAIT;
            end
            WAIT: begin
                if (bus.sm_done || timed_out) begin
                    next_state = DELIVER;
                end
            end
            DELIVER: begin
                bus.resp_valid = NUM_REQ'(1) << id;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            id          <= '0;
            cnt         <= '0;
            resp_data_q <= '0;
            sm_input_q  <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (next_state == LAUNCH) begin
                        id         <= win_id;
                        sm_input_q <= bus.req_data[win_id];
                    end
                end
                LAUNCH: begin
                    ptr <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
                    cnt <= '0;
                end
                WAIT: begin
                    // Done takes priority over a coincident timeout.
                    if (bus.sm_done) begin
                        resp_data_q <= bus.sm_output_data;
                        resp_err_q  <= 1'b0;
                    end else if (timed_out) begin
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_data     = resp_data_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.sm_input_data = sm_input_q;

endmodule

// File: doc/softmax_arbiter.md
Name: softmax_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one softmax engine among NUM_REQ requesters.
- Accepts a request, latches its input vector and launches the engine with a one-cycle start pulse.
- Waits for the engine's done, captures the result and returns it to the originating requester.
- Sits between the layer controllers (attention heads / output layer) and the single softmax instance; it also guards against a hung engine with a cycle timeout.

Parameters:
- WIDTH, 32, data word width (signed fixed-point).
- FIXED_POINT_INDEX, 16, fractional bits; passed through for consistency, no arithmetic on data here.
- DIMENSION, 4, vector length handled by the engine.
- NUM_REQ, 4, number of requesters (>=2).
- TIMEOUT, 1024, max cycles to wait for engine done before aborting.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_data  in  [NUM_REQ][DIMENSION] x WIDTH signed  per-requester input vector, held stable while req high.
- grant  out  NUM_REQ  one-hot, one-cycle pulse: request accepted, data latched.
- resp_valid  out  NUM_REQ  one-hot, one-cycle pulse: result for that requester on resp_data.
- resp_data  out  [DIMENSION] x WIDTH signed  shared result vector, held until the next capture.
- resp_err  out  1  qualifies resp_valid: 1 means the job timed out and resp_data is all zero.
- busy  out  1  high in every state except IDLE.
- sm_start  out  1  one-cycle start pulse to the engine.
- sm_input_data  out  [DIMENSION] x WIDTH signed  latched vector to the engine, stable from LAUNCH through WAIT.
- sm_output_data  in  [DIMENSION] x WIDTH signed  engine result.
- sm_done  in  1  engine completion.
- sm_busy  in  1  engine busy.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr pointer=0, grant/resp_valid/sm_start/resp_err/busy=0, resp_data and sm_input_data all zero, timeout counter=0.
- Reset mid-job drops the in-flight job silently; no resp_valid is issued for it. The engine shares this reset.
- States: IDLE, LAUNCH, WAIT, DELIVER.
- IDLE:
  - If any req is set and sm_busy=0, select the winner as the first set req at or after the pointer, wrapping modulo NUM_REQ.
  - In that same cycle, register the winner's req_data into sm_input_data, record the winner id and pulse grant[id] on the next cycle edge. Go to LAUNCH.
  - If sm_busy=1, nothing is granted and the state stays IDLE.
- LAUNCH: sm_start=1 for exactly this cycle. Set pointer=(id+1) mod NUM_REQ. Clear the timeout counter. Go to WAIT.
- WAIT:
  - sm_done is sampled only in this state; a done level present during LAUNCH is ignored.
  - On sm_done=1: capture sm_output_data into resp_data, set resp_err=0, go to DELIVER.
  - Otherwise increment the counter. When it reaches TIMEOUT-1: load resp_data with zeros, set resp_err=1, go to DELIVER.
  - Done and timeout in the same cycle: done wins.
- DELIVER: resp_valid[id]=1 for one cycle with resp_err valid. Go to IDLE.
- Back-to-back grant is possible in the cycle after DELIVER.
- Latency:
  - grant pulse is visible at cycle T+1 after req is sampled in IDLE at T; sm_start is high in that same T+1 cycle.
  - resp_valid is high one cycle after sm_done is sampled.
  - Fixed overhead is 3 cycles plus engine latency.
- Fairness: a continuously asserted req is served within NUM_REQ jobs.
- Requester contract: keep req high until grant. Dropping req before grant is legal and simply results in no grant. After grant the arbiter never re-reads req_data.
- Widths: data is passed through unmodified; the counter is $clog2(TIMEOUT+1) bits; the id is $clog2(NUM_REQ) bits.

Decomposition:
- softmax_pkg: WIDTH/FIXED_POINT_INDEX default constants, a typedef for the arbiter state enum, a typedef for a signed data word.
- Sub-module rr_arbiter: combinational pick of the first set req at or after the pointer, with wrap; outputs a valid flag and a winner id. The pointer register stays in softmax_arbiter.

Test Plan:
- Single request: req[0]=1 with [1.0,2.0,3.0,4.0] (0x00010000..0x00040000) → one grant[0] pulse.
  - Then sm_start exactly once, resp_valid[0] once, resp_err=0.
  - resp_data equals sm_output_data at sm_done, about [0x0838,0x164D,0x3CA7,0xA4D6] within 1%.
- All four req high simultaneously from reset, distinct vectors → grant order 0,1,2,3, then 0 again if still high.
  - Each resp_valid[i] matches its own input's softmax; all-zero input gives 0x4000 in every lane.
- Pointer at 2 with only req[1] and req[3] set → grant[3] first, then grant[1].
- sm_busy forced high in IDLE with req[2]=1 → no grant while it is high; grant one cycle after sm_busy falls.
- Engine stub never asserts sm_done, TIMEOUT=16 → resp_valid[id] with resp_err=1 and resp_data all zero, 16 cycles after LAUNCH; next request proceeds normally.
- reset driven low during WAIT → all outputs zero immediately (async) and no resp_valid for the dropped job; a request after release gets the first-at-or-after scan from pointer 0.
